// File: rtl/axi_slv_pkg.sv
// Shared encodings and address-decode helpers for the AXI3 SRAM responder.
package axi_slv_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } state_t;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned mem_aw);
    return (addr >> (mem_aw + 32'd2)) == 32'd0;
  endfunction

  // WRAP and the reserved encoding run as INCR but are flagged SLVERR.
  function automatic logic [1:0] decode_resp(input logic [31:0] addr, input logic [1:0] burst,
                                             input int unsigned mem_aw);
    logic [1:0] resp;
    if (!addr_in_range(addr, mem_aw)) begin
      resp = RESP_DECERR;
    end else if (burst[1]) begin
      resp = RESP_SLVERR;
    end else begin
      resp = RESP_OKAY;
    end
    return resp;
  endfunction

endpackage

// File: rtl/axi_slv_mem.sv
// Word-addressed 32-bit memory: asynchronous read, byte-enable synchronous write.
module axi_slv_mem #(
  parameter int    MEM_AW    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic [MEM_AW-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder in front of a byte-writable SRAM, one transaction at a time.
// Define AXI_SLV_STALL_EN to insert periodic R/W backpressure bubbles.
module axi_sram_slave #(
  parameter int    MEM_AW    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  import axi_slv_pkg::*;

`ifdef AXI_SLV_STALL_EN
  localparam logic STALL_EN = 1'b1;
`else
  localparam logic STALL_EN = 1'b0;
`endif

  localparam logic [MEM_AW-1:0] IDX_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  state_t            state;
  logic              prio_rd;
  logic              stall;
  logic [1:0]        beat_cnt;
  logic [MEM_AW-1:0] rd_idx;
  logic [MEM_AW-1:0] rd_next;
  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] mem_raddr;
  logic [3:0]        rd_len;
  logic [3:0]        rd_beat;
  logic [3:0]        wr_len;
  logic [3:0]        wr_cnt;
  logic              rd_fixed;
  logic              rd_dec;
  logic              wr_fixed;
  logic              wr_dec;
  logic [1:0]        wr_base;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic              ar_dec;
  logic              aw_dec;
  logic              unused;

  assign ar_dec  = !addr_in_range(araddr, MEM_AW);
  assign aw_dec  = !addr_in_range(awaddr, MEM_AW);
  assign arready = (state == IDLE) && !rst && arvalid && (!awvalid || prio_rd);
  assign awready = (state == IDLE) && !rst && awvalid && (!arvalid || !prio_rd);
  assign rd_next = rd_fixed ? rd_idx : rd_idx + IDX_ONE;
  assign mem_we  = (state == WR_DATA) && wvalid && wready && !wr_dec;

  assign unused = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot,
                    wid, araddr[1:0], awaddr[1:0]};

  // In IDLE the array is looked up at the incoming AR address so beat 0 is ready at T+1.
  always_comb begin
    if (state == IDLE) begin
      mem_raddr = araddr[MEM_AW+1:2];
    end else begin
      mem_raddr = rd_next;
    end
  end

  axi_slv_mem #(
    .MEM_AW    (MEM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_idx),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Transaction FSM with registered R, W-ready and B outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prio_rd  <= 1'b1;
      stall    <= 1'b0;
      beat_cnt <= 2'd0;
      rd_idx   <= '0;
      rd_len   <= 4'd0;
      rd_beat  <= 4'd0;
      rd_fixed <= 1'b0;
      rd_dec   <= 1'b0;
      wr_idx   <= '0;
      wr_len   <= 4'd0;
      wr_cnt   <= 4'd0;
      wr_fixed <= 1'b0;
      wr_dec   <= 1'b0;
      wr_base  <= RESP_OKAY;
      rid      <= 4'd0;
      rdata    <= 32'd0;
      rresp    <= RESP_OKAY;
      rlast    <= 1'b0;
      rvalid   <= 1'b0;
      wready   <= 1'b0;
      bid      <= 4'd0;
      bresp    <= RESP_OKAY;
      bvalid   <= 1'b0;
    end else begin
      if (arvalid && awvalid && (arready || awready)) begin
        prio_rd <= !prio_rd;
      end
      case (state)
        IDLE: begin
          if (arready) begin
            state    <= RD;
            rd_idx   <= araddr[MEM_AW+1:2];
            rd_len   <= arlen;
            rd_beat  <= 4'd0;
            rd_fixed <= (arburst == BURST_FIXED);
            rd_dec   <= ar_dec;
            rid      <= arid;
            rresp    <= decode_resp(araddr, arburst, MEM_AW);
            rdata    <= ar_dec ? 32'd0 : mem_rdata;
            rlast    <= (arlen == 4'd0);
            rvalid   <= 1'b1;
          end else if (awready) begin
            state    <= WR_DATA;
            wr_idx   <= awaddr[MEM_AW+1:2];
            wr_len   <= awlen;
            wr_cnt   <= 4'd0;
            wr_fixed <= (awburst == BURST_FIXED);
            wr_dec   <= aw_dec;
            wr_base  <= decode_resp(awaddr, awburst, MEM_AW);
            bid      <= awid;
            wready   <= 1'b1;
          end else begin
            stall <= 1'b0;
          end
        end
        RD: begin
          if (rvalid && rready) begin
            beat_cnt <= beat_cnt + 2'd1;
            if (rlast) begin
              state  <= IDLE;
              rvalid <= 1'b0;
              rlast  <= 1'b0;
            end else begin
              rd_idx  <= rd_next;
              rd_beat <= rd_beat + 4'd1;
              rdata   <= rd_dec ? 32'd0 : mem_rdata;
              rlast   <= (rd_beat + 4'd1 == rd_len);
              // Bubble ahead of every 4th beat when stalling is built in.
              if (STALL_EN && beat_cnt == 2'd2) begin
                rvalid <= 1'b0;
                stall  <= 1'b1;
              end else begin
                rvalid <= 1'b1;
              end
            end
          end else if (stall) begin
            rvalid <= 1'b1;
            stall  <= 1'b0;
          end else begin
            rvalid <= rvalid;
          end
        end
        WR_DATA: begin
          if (wvalid && wready) begin
            beat_cnt <= beat_cnt + 2'd1;
            wr_cnt   <= wr_cnt + 4'd1;
            if (!wr_fixed) begin
              wr_idx <= wr_idx + IDX_ONE;
            end
            if (wlast) begin
              state  <= WR_RESP;
              wready <= 1'b0;
              bvalid <= 1'b1;
              if (wr_base == RESP_DECERR) begin
                bresp <= RESP_DECERR;
              end else if (wr_cnt != wr_len) begin
                bresp <= RESP_SLVERR;
              end else begin
                bresp <= wr_base;
              end
            end else if (STALL_EN && beat_cnt == 2'd3) begin
              wready <= 1'b0;
              stall  <= 1'b1;
            end else begin
              wready <= 1'b1;
            end
          end else if (stall) begin
            wready <= 1'b1;
            stall  <= 1'b0;
          end else begin
            wready <= wready;
          end
        end
        WR_RESP: begin
          if (bready) begin
            state  <= IDLE;
            bvalid <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          rvalid <= 1'b0;
          wready <= 1'b0;
          bvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule
